// File: rtl/mul_control_pkg.sv
// Shared types and constants for the iterative shift-add multiplier control.
package mul_pkg;

   // Operand width of b, which is also the number of shift-add iterations.
   localparam int NBITS = 32;

   // a/b operand muxes: load from the input message or take the shifted value.
   localparam logic SEL_LOAD  = 1'b0;
   localparam logic SEL_SHIFT = 1'b1;

   // Result mux: clear to zero or take the add-mux path.
   localparam logic SEL_CLR   = 1'b0;
   localparam logic SEL_ADD   = 1'b1;

   // Controller state. The 2'b11 encoding is unused and recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } mul_state_t;

endpackage

// File: rtl/mul_control_if.sv
// Control/status bundle between the multiplier controller and its datapath.
//
// Handshake rules: a transfer on a stream happens at a rising clk edge where
// both val and rdy are high. A producer holds val (and its message) high and
// stable until that edge; val never depends combinationally on rdy.
interface mul_control_if;
   logic istream_val;
   logic istream_rdy;
   logic ostream_val;
   logic ostream_rdy;
   logic b_lsb;
   logic a_mux_sel;
   logic b_mux_sel;
   logic r_mux_sel;
   logic add_mux_sel;
   logic r_en;
   logic busy;

   // Controller side.
   modport master (
      input  istream_val, ostream_rdy, b_lsb,
      output istream_rdy, ostream_val, a_mux_sel, b_mux_sel,
             r_mux_sel, add_mux_sel, r_en, busy
   );

   // Datapath / environment side.
   modport slave (
      output istream_val, ostream_rdy, b_lsb,
      input  istream_rdy, ostream_val, a_mux_sel, b_mux_sel,
             r_mux_sel, add_mux_sel, r_en, busy
   );
endinterface

// File: rtl/mul_control.sv
// Controller for the iterative shift-add multiplier. It accepts one operand
// message, steers the datapath through NBITS shift-add iterations and then
// presents the product until the consumer takes it. No data passes through.
module mul_control
   import mul_pkg::*;
#(
   parameter int NBITS = mul_pkg::NBITS,
   parameter int CNT_W = $clog2(NBITS)
) (
   input  logic          clk,
   input  logic          rst_n,
   mul_control_if.master ctl,
   output mul_state_t    o_dbg_state
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NBITS - 1);

   mul_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;

   logic w_istream_rdy;
   logic w_ostream_val;
   logic w_a_mux_sel;
   logic w_b_mux_sel;
   logic w_r_mux_sel;
   logic w_add_mux_sel;
   logic w_r_en;
   logic w_busy;

   // State and iteration counter: accept in IDLE, count NBITS edges in CALC,
   // hold the product in DONE until the consumer is ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               // istream_rdy is high throughout IDLE, so val alone completes it.
               if (ctl.istream_val) begin
                  r_state <= CALC;
                  r_cnt   <= '0;
               end
            end
            CALC: begin
               if (r_cnt == LAST_ITER) begin
                  r_state <= DONE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               if (ctl.ostream_rdy) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Output decode from the registered state; add_mux_sel alone also follows
   // b_lsb so the adder is steered in the same cycle the LSB is visible.
   always_comb begin
      w_istream_rdy = 1'b1;
      w_ostream_val = 1'b0;
      w_a_mux_sel   = SEL_LOAD;
      w_b_mux_sel   = SEL_LOAD;
      w_r_mux_sel   = SEL_CLR;
      w_add_mux_sel = 1'b0;
      w_r_en        = 1'b1;
      w_busy        = 1'b0;
      case (r_state)
         CALC: begin
            w_istream_rdy = 1'b0;
            w_a_mux_sel   = SEL_SHIFT;
            w_b_mux_sel   = SEL_SHIFT;
            w_r_mux_sel   = SEL_ADD;
            w_add_mux_sel = ctl.b_lsb;
            w_busy        = 1'b1;
         end
         DONE: begin
            w_istream_rdy = 1'b0;
            w_ostream_val = 1'b1;
            w_a_mux_sel   = SEL_SHIFT;
            w_b_mux_sel   = SEL_SHIFT;
            w_r_mux_sel   = SEL_ADD;
            w_r_en        = 1'b0;
            w_busy        = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign ctl.istream_rdy = w_istream_rdy;
   assign ctl.ostream_val = w_ostream_val;
   assign ctl.a_mux_sel   = w_a_mux_sel;
   assign ctl.b_mux_sel   = w_b_mux_sel;
   assign ctl.r_mux_sel   = w_r_mux_sel;
   assign ctl.add_mux_sel = w_add_mux_sel;
   assign ctl.r_en        = w_r_en;
   assign ctl.busy        = w_busy;
   assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mul_control.sv
// Bench for mul_control: a behavioural shift-add datapath closes the loop so
// products can be checked; a monitor pops expected products on each output
// handshake.
module tb_mul_control;
  import mul_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  mul_state_t dbg_state;

  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic [W-1:0] r_reg;

  int checks;
  int errors;
  logic [W-1:0] exp_q[$];
  time accept_t;

  mul_control_if u_if ();

  mul_control u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctl         (u_if.master),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural datapath ----------------
  always @(posedge clk) begin
    a_reg <= u_if.a_mux_sel ? (a_reg << 1) : in_a;
    b_reg <= u_if.b_mux_sel ? (b_reg >> 1) : in_b;
    if (u_if.r_en)
      r_reg <= u_if.r_mux_sel ? (u_if.add_mux_sel ? a_reg + r_reg : r_reg) : '0;
  end
  assign u_if.b_lsb = b_reg[0];

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=0x%0h req=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && u_if.ostream_val && u_if.ostream_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_product", 32'd1, 32'd0);
      end else begin
        check("product", r_reg, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One transaction: present operands, verify the CALC phase and the DONE
  // entry, optionally stall the consumer for 'hold' cycles.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] prod, input int hold, input bit keep_val);
    logic [W-1:0] sel_seen;
    logic [W-1:0] r_snap;
    bit calc_ok;
    bit hold_ok;
    @(posedge clk); #1;
    in_a = a;
    in_b = b;
    u_if.istream_val = 1'b1;
    u_if.ostream_rdy = (hold == 0);
    @(negedge clk);
    check("accept_rdy", {31'd0, u_if.istream_rdy}, 32'd1);
    exp_q.push_back(prod);
    @(posedge clk);
    accept_t = $time;
    #1;
    if (!keep_val) u_if.istream_val = 1'b0;
    calc_ok  = 1'b1;
    sel_seen = '0;
    for (int i = 0; i < NBITS; i++) begin
      @(negedge clk);
      sel_seen[i] = u_if.add_mux_sel;
      if (u_if.ostream_val !== 1'b0 || u_if.istream_rdy !== 1'b0 ||
          u_if.busy !== 1'b1 || u_if.r_en !== 1'b1 || dbg_state !== CALC)
        calc_ok = 1'b0;
    end
    check("calc_flags", {31'd0, calc_ok}, 32'd1);
    check("add_sel_pattern", sel_seen, b);
    @(negedge clk);
    check("latency_val", {31'd0, u_if.ostream_val}, 32'd1);
    check("done_r_en", {31'd0, u_if.r_en}, 32'd0);
    if (hold > 0) begin
      r_snap  = r_reg;
      hold_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (u_if.ostream_val !== 1'b1 || u_if.istream_rdy !== 1'b0 ||
            r_reg !== r_snap || dbg_state !== DONE)
          hold_ok = 1'b0;
      end
      check("backpressure_hold", {31'd0, hold_ok}, 32'd1);
      @(posedge clk); #1;
      u_if.ostream_rdy = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("return_idle_rdy", {31'd0, u_if.istream_rdy}, 32'd1);
      check("return_idle_busy", {31'd0, u_if.busy}, 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    time t_first;
    bit quiet;
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    u_if.istream_val = 1'b0;
    u_if.ostream_rdy = 1'b0;
    in_a = '0;
    in_b = '0;

    // Asynchronous reset mid-cycle, before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_istream_rdy", {31'd0, u_if.istream_rdy}, 32'd1);
    check("rst_ostream_val", {31'd0, u_if.ostream_val}, 32'd0);
    check("rst_busy", {31'd0, u_if.busy}, 32'd0);
    check("rst_r_en", {31'd0, u_if.r_en}, 32'd1);
    check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Plain products and LSB steering.
    run_txn(32'd3, 32'd5, 32'd15, 0, 1'b0);
    run_txn(32'd7, 32'hAAAA_AAAA, 32'hAAAA_AAA6, 0, 1'b0);

    // Consumer stalls for 10 cycles in DONE.
    run_txn(32'd6, 32'd7, 32'd42, 10, 1'b0);

    // Back-to-back with istream_val and ostream_rdy held high.
    run_txn(32'd2, 32'd3, 32'd6, 0, 1'b1);
    t_first = accept_t;
    run_txn(32'd4, 32'd5, 32'd20, 0, 1'b1);
    u_if.istream_val = 1'b0;
    check("b2b_spacing", 32'((accept_t - t_first) / 10), 32'(NBITS + 2));

    // Reset at CALC iteration 10: transaction lost, no product appears.
    @(posedge clk); #1;
    in_a = 32'd11;
    in_b = 32'd13;
    u_if.istream_val = 1'b1;
    @(posedge clk); #1;
    u_if.istream_val = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midcalc_rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    check("midcalc_rst_val", {31'd0, u_if.ostream_val}, 32'd0);
    check("midcalc_rst_busy", {31'd0, u_if.busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u_if.ostream_val !== 1'b0) quiet = 1'b0;
    end
    check("no_val_after_reset", {31'd0, quiet}, 32'd1);

    run_txn(32'd9, 32'd9, 32'd81, 0, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
